// File: rtl/loader_pkg.sv
// Shared types and constants for the program loader.
// FSM states plus stream framing sizes.
package loader_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_LO,
    S_LEN_HI,
    S_DATA,
    S_WRITE,
    S_DONE,
    S_ERROR
  } state_e;

  localparam int HDR_BYTES      = 2;
  localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/program_loader_if.sv
// Byte stream in, instruction-memory write port out.
// master = stream source / memory side, slave = loader.
interface program_loader_if #(
  parameter int ADDR_W = 5
);

  logic              byte_valid;
  logic [7:0]        byte_data;
  logic              byte_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;

  modport master (
    output byte_valid,
    output byte_data,
    input  byte_ready,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata
  );

  modport slave (
    input  byte_valid,
    input  byte_data,
    output byte_ready,
    output mem_we,
    output mem_addr,
    output mem_wdata
  );

endinterface

// File: rtl/program_loader_byte_assembler.sv
// Packs stream bytes into a little-endian 32-bit word.
// word_full flags the load that completes the current word.
module byte_assembler
  import loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        clear,
  input  logic [7:0]  byte_in,
  output logic [31:0] word,
  output logic        word_full
);

  logic [1:0]  idx_q, idx_d;
  logic [31:0] word_q, word_d;

  always_comb begin
    idx_d     = idx_q;
    word_d    = word_q;
    word_full = 1'b0;
    if (clear) begin
      idx_d = '0;
    end else if (load) begin
      word_d[{idx_q, 3'b000} +: 8] = byte_in;
      idx_d     = idx_q + 2'd1;
      word_full = (idx_q == 2'(BYTES_PER_WORD - 1));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      idx_q  <= '0;
      word_q <= '0;
    end else begin
      idx_q  <= idx_d;
      word_q <= word_d;
    end
  end

  assign word = word_q;

endmodule

// File: rtl/program_loader.sv
// Streams a length-prefixed image into instruction memory,
// holding the core in reset until the whole image is written.
module program_loader
  import loader_pkg::*;
#(
  parameter  int MEMORY_DEPTH = 32,
  localparam int ADDR_W       = $clog2(MEMORY_DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  program_loader_if.slave  bus,
  output logic             cpu_reset,
  output logic             busy,
  output logic             done,
  output logic             error
);

  localparam logic [15:0] DEPTH16 = 16'(MEMORY_DEPTH);

  state_e            state_q, state_d;
  logic [15:0]       word_cnt_q, word_cnt_d;
  logic [15:0]       len_q, len_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;

  logic        accept;
  logic        asm_load;
  logic        asm_clear;
  logic        asm_full;
  logic [31:0] asm_word;

  assign bus.byte_ready = (state_q == S_LEN_LO) ||
                          (state_q == S_LEN_HI) ||
                          (state_q == S_DATA);
  assign accept   = bus.byte_valid && bus.byte_ready;
  assign asm_load = accept && (state_q == S_DATA);

  byte_assembler u_asm (
    .clk       (clk),
    .reset     (reset),
    .load      (asm_load),
    .clear     (asm_clear),
    .byte_in   (bus.byte_data),
    .word      (asm_word),
    .word_full (asm_full)
  );

  always_comb begin
    state_d    = state_q;
    word_cnt_d = word_cnt_q;
    len_d      = len_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    asm_clear  = 1'b0;
    unique case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) begin
          state_d    = S_LEN_LO;
          word_cnt_d = '0;
          asm_clear  = 1'b1;
        end
      end
      S_LEN_LO: begin
        if (accept) begin
          len_d   = {8'h00, bus.byte_data};
          state_d = S_LEN_HI;
        end
      end
      S_LEN_HI: begin
        if (accept) begin
          len_d = {bus.byte_data, len_q[7:0]};
          if (len_d == 16'd0)
            state_d = S_DONE;
          else if (len_d > DEPTH16)
            state_d = S_ERROR;
          else
            state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (asm_full) begin
          state_d = S_WRITE;
          addr_d  = word_cnt_q[ADDR_W-1:0];
        end
      end
      S_WRITE: begin
        wdata_d    = asm_word;
        word_cnt_d = word_cnt_q + 16'd1;
        state_d    = (word_cnt_d == len_q) ? S_DONE : S_DATA;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      word_cnt_q <= '0;
      len_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      word_cnt_q <= word_cnt_d;
      len_q      <= len_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
    end
  end

  // The assembled word is complete only during WRITE; hold it afterwards.
  assign bus.mem_we    = (state_q == S_WRITE);
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = (state_q == S_WRITE) ? asm_word : wdata_q;

  assign busy      = (state_q == S_LEN_LO) || (state_q == S_LEN_HI) ||
                     (state_q == S_DATA)   || (state_q == S_WRITE);
  assign done      = (state_q == S_DONE);
  assign error     = (state_q == S_ERROR);
  assign cpu_reset = (state_q != S_DONE);

endmodule

// File: tb/tb_program_loader.sv
// Directed and randomized loads checked against a word-list model.
// Stimulus driven just after posedge, outputs sampled at negedge.
module tb_program_loader;

  logic clk = 1'b0;
  logic reset;
  logic start;
  logic cpu_reset, busy, done, error;

  program_loader_if #(.ADDR_W(5)) bus ();

  program_loader #(.MEMORY_DEPTH(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .bus       (bus),
    .cpu_reset (cpu_reset),
    .busy      (busy),
    .done      (done),
    .error     (error)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int fails   = 0;

  logic [7:0]  stream_q[$];
  logic [4:0]  wr_addr[$];
  logic [31:0] wr_data[$];
  logic [4:0]  exp_addr[$];
  logic [31:0] exp_data[$];
  int          acc_cnt;
  int          ready_in_write;

  always @(negedge clk) begin
    if (bus.mem_we) begin
      wr_addr.push_back(bus.mem_addr);
      wr_data.push_back(bus.mem_wdata);
      if (bus.byte_ready) ready_in_write++;
    end
    if (!reset && bus.byte_valid && bus.byte_ready) acc_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    wr_addr.delete();
    wr_data.delete();
    acc_cnt = 0;
    ready_in_write = 0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Header with word count n, then n random words.
  task automatic build_random(input int n);
    stream_q.delete();
    stream_q.push_back(8'(n));
    stream_q.push_back(8'(n >> 8));
    for (int i = 0; i < 4 * n; i++) stream_q.push_back(8'($urandom));
  endtask

  // Reference: words are little-endian groups of four after the header.
  task automatic model();
    int n;
    exp_addr.delete();
    exp_data.delete();
    n = int'(stream_q[0]) + 256 * int'(stream_q[1]);
    if (n <= 32) begin
      for (int k = 0; k < n; k++) begin
        exp_addr.push_back(5'(k));
        exp_data.push_back(int'(stream_q[2 + 4*k]) +
                           (int'(stream_q[3 + 4*k]) << 8) +
                           (int'(stream_q[4 + 4*k]) << 16) +
                           (int'(stream_q[5 + 4*k]) << 24));
      end
    end
  endtask

  // mode 0: valid held high, 1: toggling, 2: random
  task automatic push_stream(input int mode, input int from, input int upto);
    int i = from;
    int guard = 0;
    while (i < upto && guard < 3000) begin
      if (mode == 0) bus.byte_valid = 1'b1;
      else if (mode == 1) bus.byte_valid = ~guard[0];
      else bus.byte_valid = 1'($urandom_range(0, 1));
      bus.byte_data = bus.byte_valid ? stream_q[i] : 8'($urandom);
      @(negedge clk);
      if (bus.byte_valid && bus.byte_ready) i++;
      tick();
      guard++;
    end
    bus.byte_valid = 1'b0;
    if (i < upto) chk("push_timeout", 64'(i), 64'(upto));
  endtask

  task automatic wait_idle();
    int g = 0;
    while (busy && g < 20) begin
      tick();
      g++;
    end
    if (busy) chk("idle_timeout", 64'(busy), 64'd0);
  endtask

  task automatic check_writes(input string tag);
    chk({tag, "_nwr"}, 64'(wr_addr.size()), 64'(exp_addr.size()));
    for (int k = 0; k < exp_addr.size() && k < wr_addr.size(); k++) begin
      chk({tag, "_addr"}, 64'(wr_addr[k]), 64'(exp_addr[k]));
      chk({tag, "_data"}, 64'(wr_data[k]), 64'(exp_data[k]));
    end
    chk({tag, "_rdy_in_wr"}, 64'(ready_in_write), 64'd0);
  endtask

  task automatic check_reset_outs(input string tag);
    chk(tag, {bus.byte_ready, bus.mem_we, bus.mem_addr, bus.mem_wdata,
              cpu_reset, busy, done, error},
        {1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0});
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    bus.byte_valid = 1'b0;
    bus.byte_data  = 8'h00;
    tick();
    tick();
    reset = 1'b0;
    check_reset_outs("reset_outs");

    // Fixed two-word image, valid held high
    clear_mon();
    pulse_start();
    chk("start_ready", 64'(bus.byte_ready), 64'd1);
    chk("start_busy", 64'(busy), 64'd1);
    stream_q = '{8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12,
                 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    model();
    push_stream(0, 0, stream_q.size());
    chk("last_we", 64'(bus.mem_we), 64'd1);
    chk("last_rdy", 64'(bus.byte_ready), 64'd0);
    chk("last_done_early", 64'(done), 64'd0);
    tick();
    chk("fix_done", {done, cpu_reset, bus.mem_we}, {1'b1, 1'b0, 1'b0});
    check_writes("fix");
    chk("fix_acc", 64'(acc_cnt), 64'(stream_q.size()));

    // Same image, valid toggling
    clear_mon();
    pulse_start();
    push_stream(1, 0, stream_q.size());
    wait_idle();
    check_writes("tog");
    chk("tog_acc", 64'(acc_cnt), 64'(stream_q.size()));
    chk("tog_done", {done, cpu_reset, error}, {1'b1, 1'b0, 1'b0});

    // Zero-length header
    clear_mon();
    pulse_start();
    stream_q = '{8'h00, 8'h00};
    model();
    push_stream(0, 0, 2);
    chk("zero_state", {done, error, busy, cpu_reset},
        {1'b1, 1'b0, 1'b0, 1'b0});
    tick();
    check_writes("zero");

    // Oversized header
    clear_mon();
    pulse_start();
    stream_q = '{8'h21, 8'h00};
    model();
    push_stream(0, 0, 2);
    chk("err_state", {error, done, cpu_reset, bus.byte_ready},
        {1'b1, 1'b0, 1'b1, 1'b0});
    bus.byte_valid = 1'b1;
    repeat (4) tick();
    bus.byte_valid = 1'b0;
    chk("err_acc", 64'(acc_cnt), 64'd2);
    chk("err_hold", {error, cpu_reset}, {1'b1, 1'b1});
    check_writes("err");
    pulse_start();
    chk("err_clear", {error, busy}, {1'b0, 1'b1});
    clear_mon();
    build_random(3);
    model();
    push_stream(2, 0, stream_q.size());
    wait_idle();
    check_writes("after_err");

    // Full-depth image
    clear_mon();
    pulse_start();
    build_random(32);
    model();
    push_stream(0, 0, stream_q.size());
    wait_idle();
    repeat (5) tick();
    check_writes("full");
    chk("full_done", {done, cpu_reset}, {1'b1, 1'b0});
    if (wr_addr.size() > 0)
      chk("full_last_addr", 64'(wr_addr[wr_addr.size()-1]), 64'd31);

    // Reset mid-word, then reload with a stray start
    clear_mon();
    pulse_start();
    build_random(3);
    push_stream(0, 0, 8);
    chk("mid_busy", 64'(busy), 64'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_reset_outs("mid_reset_outs");
    clear_mon();
    pulse_start();
    build_random(4);
    model();
    push_stream(0, 0, 2);
    pulse_start();
    chk("stray_start", {busy, bus.byte_ready}, {1'b1, 1'b1});
    push_stream(2, 2, stream_q.size());
    wait_idle();
    check_writes("reload");

    // Random loads
    for (int r = 0; r < 6; r++) begin
      clear_mon();
      pulse_start();
      build_random(int'($urandom_range(1, 10)));
      model();
      push_stream(int'($urandom_range(0, 2)), 0, stream_q.size());
      wait_idle();
      check_writes("rand");
      chk("rand_done", {done, cpu_reset, error}, {1'b1, 1'b0, 1'b0});
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
